// File: rtl/mem_dump_reader.sv
// Streams a window of 64-bit data-memory words (with byte addresses) over valid/ready.
// Optional: define DUMP_SKIP_ZERO_EN to drop all-zero words from the stream.
module mem_dump_reader #(
   parameter logic [63:0] BASE_ADDR  = 64'h0,
   parameter int unsigned WORD_COUNT = 256,
   parameter int unsigned CNT_W      = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        mem_rd_en,
   output logic [63:0] mem_addr,
   input  logic [63:0] mem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_addr,
   output logic [63:0] out_data,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_SEND,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_COUNT - 1);

   state_t           state, state_nx;
   logic [CNT_W-1:0] count;
   logic             last, skip, retire, accept;

   assign mem_rd_en = (state == S_READ);
   assign last      = (count == LAST_IDX);

   always_comb begin
      state_nx = state;
      skip     = 1'b0;
      retire   = 1'b0;
      accept   = 1'b0;
`ifdef DUMP_SKIP_ZERO_EN
      skip     = (mem_rdata == '0);
`endif
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = S_READ;
            end
         end
         S_READ: state_nx = S_WAIT;
         S_WAIT: begin
            // a skipped word retires straight from WAIT as if handshaken
            if (skip) begin
               retire   = 1'b1;
               state_nx = last ? S_DONE : S_READ;
            end else begin
               state_nx = S_SEND;
            end
         end
         S_SEND: begin
            if (out_valid && out_ready) begin
               retire   = 1'b1;
               state_nx = last ? S_DONE : S_READ;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         count     <= '0;
         mem_addr  <= '0;
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            done     <= 1'b0;
            busy     <= 1'b1;
            count    <= '0;
            mem_addr <= BASE_ADDR;
         end
         if (state == S_WAIT && !skip) begin
            out_data  <= mem_rdata;
            out_addr  <= mem_addr;
            out_valid <= 1'b1;
         end
         if (retire) begin
            out_valid <= 1'b0;
            if (last) begin
               busy <= 1'b0;
               done <= 1'b1;
            end else begin
               count    <= count + 1'b1;
               mem_addr <= mem_addr + 64'd8;
            end
         end
      end
   end

endmodule
